// File: rtl/reg_sb_pkg.sv
// Shared scoreboard definitions: default sizing for the register
// scoreboard, reused by the ID stage and the forwarding unit.
package reg_sb_pkg;

    localparam int SB_NUM_REGS = 16;
    localparam int SB_REG_W    = 4;
    localparam int SB_CNT_W    = 2;

    typedef logic [SB_REG_W-1:0] reg_idx_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/query bundle between the pipeline and the scoreboard.
interface reg_scoreboard_if
    import reg_sb_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int REG_W    = SB_REG_W
);

    logic                issue_valid;
    logic                issue_wb_en;
    logic [REG_W-1:0]    issue_dest;
    logic                wb_valid;
    logic [REG_W-1:0]    wb_dest;
    logic [REG_W-1:0]    src1;
    logic [REG_W-1:0]    src2;
    logic                with_two_source;
    logic                src1_busy;
    logic                src2_busy;
    logic                hazard_detected;
    logic                issue_full;
    logic [NUM_REGS-1:0] pending_mask;
    logic                err_overflow;
    logic                err_underflow;

    // Pipeline side: drives issue/wb/query, observes answers.
    modport master (
        output issue_valid, issue_wb_en, issue_dest, wb_valid, wb_dest,
               src1, src2, with_two_source,
        input  src1_busy, src2_busy, hazard_detected, issue_full,
               pending_mask, err_overflow, err_underflow
    );

    // Scoreboard side.
    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, wb_valid, wb_dest,
               src1, src2, with_two_source,
        output src1_busy, src2_busy, hazard_detected, issue_full,
               pending_mask, err_overflow, err_underflow
    );

endinterface

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one register.
// A simultaneous inc and dec leaves the count unchanged, except at zero
// where the dec has nothing to remove and the inc still lands.
module sb_counter
    import reg_sb_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             zero
);

    assign full = (cnt == {CNT_W{1'b1}});
    assign zero = (cnt == '0);

    // Count update: guarded at both ends so the value never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            unique case ({inc, dec})
                2'b10:   if (!full) cnt <= cnt + CNT_W'(1);
                2'b01:   if (!zero) cnt <= cnt - CNT_W'(1);
                2'b11:   if (zero)  cnt <= cnt + CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard. Destinations are counted in as
// they leave ID and counted out as WB commits them; source queries are
// answered from the stored counts plus an optional writeback bypass.
module reg_scoreboard
    import reg_sb_pkg::*;
#(
    parameter int NUM_REGS  = SB_NUM_REGS,
    parameter int REG_W     = SB_REG_W,
    parameter int CNT_W     = SB_CNT_W,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] zero;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic                same_reg;
    logic                err_ovf;
    logic                err_unf;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        assign inc[r] = sb.issue_valid & sb.issue_wb_en & (sb.issue_dest == REG_W'(r));
        assign dec[r] = sb.wb_valid & (sb.wb_dest == REG_W'(r));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .inc  (inc[r]),
            .dec  (dec[r]),
            .cnt  (cnt[r]),
            .full (full[r]),
            .zero (zero[r])
        );

        // The register file writes on negedge, so a last pending write
        // committing now is already readable by the ID stage.
        assign busy[r] = !zero[r] &
                         !(WB_BYPASS && dec[r] && (cnt[r] == CNT_W'(1)));
    end

    // A same-register writeback frees the slot the issue would take.
    assign same_reg       = sb.wb_valid & (sb.wb_dest == sb.issue_dest);
    assign sb.issue_full  = full[sb.issue_dest] & !same_reg;

    assign sb.src1_busy       = busy[sb.src1];
    assign sb.src2_busy       = sb.with_two_source & busy[sb.src2];
    assign sb.hazard_detected = sb.src1_busy | sb.src2_busy;
    assign sb.pending_mask    = ~zero;

    // Sticky protocol-error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            if (sb.issue_valid & sb.issue_wb_en & sb.issue_full) err_ovf <= 1'b1;
            if (sb.wb_valid & zero[sb.wb_dest])                  err_unf <= 1'b1;
        end
    end

    assign sb.err_overflow  = err_ovf;
    assign sb.err_underflow = err_unf;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Per-register pending-write scoreboard for the 5-stage ARM pipeline. It is the producer-side companion to the ID-stage hazard check. Destinations are recorded as instructions leave ID with WB_EN set, and cleared when the writeback stage commits them. It answers src1/src2 busy queries from stored state, so stalls stay correct for any in-flight depth, not only EXE/MEM.

## Interface
Parameters:
- NUM_REGS, 16, architectural registers tracked (R0–R15)
- REG_W, 4, register index width
- CNT_W, 2, per-register pending counter width (max 2^CNT_W−1 in flight)
- WB_BYPASS, 1, 1 = a register whose last pending write commits this cycle reads as not busy (register file writes on negedge)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction moves ID→EXE this cycle (already gated by freeze/flush)
- issue_wb_en  in  1  that instruction writes a register
- issue_dest  in  REG_W  its destination
- wb_valid  in  1  WB stage commits a register write this cycle
- wb_dest  in  REG_W  committed destination
- src1  in  REG_W  ID-stage first source
- src2  in  REG_W  ID-stage second source
- with_two_source  in  1  src2 is meaningful
- src1_busy  out  1  src1 has a pending write
- src2_busy  out  1  src2 has a pending write (qualified by with_two_source)
- hazard_detected  out  1  src1_busy | src2_busy
- issue_full  out  1  issue_dest counter saturated; issue would be refused
- pending_mask  out  NUM_REGS  bit r = counter r nonzero
- err_overflow  out  1  sticky: issue attempted while issue_full
- err_underflow  out  1  sticky: wb_valid to a register with counter 0

## Operation
- Incrementing: issue_valid & issue_wb_en & !issue_full → cnt[issue_dest] += 1.
- Decrementing: wb_valid & cnt[wb_dest] != 0 → cnt[wb_dest] −= 1.
- Issue and wb to the same register in the same cycle: the counter is unchanged. The increment is not gated by issue_full in this case, because the net count does not grow.
- issue_full = (cnt[issue_dest] == 2^CNT_W−1) & !(wb_valid & wb_dest == issue_dest).
- Refused issue (issue_full): the counter is held and err_overflow is set. Upstream must stall on issue_full.
- wb_valid to a zero counter: no change and err_underflow is set. A simultaneous issue to that register still increments.
- Busy: busy(r) = cnt[r] != 0, except when WB_BYPASS=1 and wb_valid & wb_dest == r & cnt[r] == 1. In that case busy(r) = 0.
- src2_busy = with_two_source & busy(src2).
- Queries see only registered counters plus the wb bypass. An issue in the same cycle does not affect the same-cycle query.
- Error flags clear only on reset.
- No flush input. Flushed instructions never assert issue_valid, and instructions past ID always reach WB.

## Timing
- Reset (async, rst_n=0): all counters 0, pending_mask=0, all busy/hazard/full outputs 0, err_* = 0. Reset is effective immediately, even mid-burst.
- Counter/error update: rising clk. Issue at cycle n → busy visible from cycle n+1.
- Busy, hazard, issue_full are combinational from counters plus the current inputs (same cycle).
- pending_mask is combinational from counters only, with no bypass.
- Wrap-around: counters never wrap. Saturation and zero are guarded as above.

## Structure
- Shared package reg_sb_pkg holds NUM_REGS, REG_W, CNT_W defaults and the reg_idx_t / sb_cnt_t typedefs. It is reused by the ID stage and the forwarding unit.
- One sub-module, sb_counter: a single saturating up/down counter with inc/dec/full/zero outputs.
- sb_counter is instantiated NUM_REGS times via generate. The top level holds decode, query muxes, bypass, and the error flags.

## Test plan
- Reset then query: rst_n low mid-run with cnt[3]=2 → next cycle src1=3 gives src1_busy=0 and pending_mask=0; err flags 0.
- Issue R5 at cycle 1 (wb_en=1) with query src1=5 at cycle 1 → busy=0 at cycle 1 and busy=1 at cycle 2. wb R5 at cycle 4 with WB_BYPASS=1 → busy=0 at cycle 4 and cnt 0 at cycle 5.
- Issue R2 ×3 back-to-back → issue_full=1 on the fourth attempt, cnt stays 3, err_overflow=1. Same attempt with wb R2 in the same cycle → accepted, cnt stays 3, no error.
- Simultaneous issue R7 and wb R7 with cnt[7]=1 → cnt stays 1, busy(7)=1 next cycle.
- src2=9 busy with with_two_source=0 → src2_busy=0 and hazard_detected=0. Set with_two_source=1 → both 1.
- wb R0 with cnt[0]=0 → err_underflow=1 and sticky until rst_n; cnt[0] stays 0.
